dma_channel_scheduler: RTL and testbench

Sequences the one-way DMA engine and shares it between NUM_CH requesters (readout channels).
- Round-robin arbitration among pending channel requests.
- Latches the winner's descriptor (target address, source address, length) and pulses begin_dma.
- Monitors dma_active / dma_complete_ok / dma_err and returns a per-channel done or error pulse.
- Enforces a programmable watchdog timeout, using abort_dma on expiry or on software abort.

---
 rtl/dma_sched_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 23 ++
 rtl/dma_channel_scheduler.sv | 101 ++++++++++
 tb/tb_dma_channel_scheduler.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_sched_pkg.sv
// dma_sched_pkg: shared FSM encodings, timing constants and descriptor widths for the DMA channel scheduler
package dma_sched_pkg;
  localparam logic [2:0] FLUSH      = 3'd0;
  localparam logic [2:0] IDLE       = 3'd1;
  localparam logic [2:0] LAUNCH     = 3'd2;
  localparam logic [2:0] WAIT_START = 3'd3;
  localparam logic [2:0] RUN        = 3'd4;
  localparam logic [2:0] ABORT      = 3'd5;
  localparam logic [2:0] DONE       = 3'd6;
  localparam logic [2:0] ERR        = 3'd7;
  localparam int START_TMO   = 4;
  localparam int ABORT_DRAIN = 2;
  localparam int TGT_W       = 32;
  localparam int RD_W        = 20;
  localparam int LEN_W       = 10;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from ptr with wrap
module rr_arbiter
  import dma_sched_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int CH_BITS = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0]  req,
  input  logic [CH_BITS-1:0] ptr,
  output logic [NUM_CH-1:0]  gnt,
  output logic [CH_BITS-1:0] idx
);
  logic [NUM_CH-1:0] rot;
  logic [CH_BITS:0]  sum;
  // rotate requests so ptr sits at bit 0, take the lowest set offset, map it back to a channel index
  always_comb begin
    rot = NUM_CH'({req, req} >> ptr);
    sum = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) sum = rot[i] ? (CH_BITS+1)'(ptr) + (CH_BITS+1)'(i) : sum;
    idx = CH_BITS'(sum >= (CH_BITS+1)'(NUM_CH) ? sum - (CH_BITS+1)'(NUM_CH) : sum);
    gnt = |req ? NUM_CH'(1) << idx : '0;
  end
endmodule

// File: rtl/dma_channel_scheduler.sv
// dma_channel_scheduler: shares one DMA engine among NUM_CH channels with round-robin grants and a watchdog
module dma_channel_scheduler
  import dma_sched_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int CH_BITS  = 2,
  parameter int TMO_BITS = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    enable_i,
  input  logic                    sw_abort_i,
  input  logic [TMO_BITS-1:0]     timeout_i,
  input  logic [NUM_CH-1:0]       ch_req_i,
  input  logic [TGT_W*NUM_CH-1:0] ch_tgt_addr_i,
  input  logic [RD_W*NUM_CH-1:0]  ch_rd_addr_i,
  input  logic [LEN_W*NUM_CH-1:0] ch_len_i,
  output logic [NUM_CH-1:0]       ch_grant_o,
  output logic [NUM_CH-1:0]       ch_done_o,
  output logic [NUM_CH-1:0]       ch_err_o,
  output logic [TGT_W-1:0]        target_begin_address,
  output logic [RD_W-1:0]         rd_address,
  output logic [LEN_W-1:0]        transfer_length,
  output logic                    begin_dma,
  output logic                    abort_dma,
  input  logic                    dma_active,
  input  logic                    dma_complete_ok,
  input  logic                    dma_err,
  output logic                    busy_o,
  output logic [CH_BITS-1:0]      cur_ch_o,
  output logic                    tmo_flag_o
);
  logic [2:0]          state;
  logic [TMO_BITS-1:0] cnt;
  logic [NUM_CH-1:0]   own, arb_gnt;
  logic [CH_BITS-1:0]  ptr, arb_idx;
  logic                tmo_hit;
  rr_arbiter #(.NUM_CH(NUM_CH), .CH_BITS(CH_BITS)) u_arb (
    .req(ch_req_i),
    .ptr(ptr),
    .gnt(arb_gnt),
    .idx(arb_idx)
  );
  assign tmo_hit    = timeout_i != '0 && cnt == timeout_i;
  assign begin_dma  = state == LAUNCH;
  assign abort_dma  = state == FLUSH || (state == ABORT && cnt == '0);
  assign busy_o     = state != IDLE && state != FLUSH;
  assign ch_grant_o = (state inside {LAUNCH, WAIT_START, RUN, ABORT}) ? own : '0;
  assign ch_done_o  = state == DONE ? own : '0;
  assign ch_err_o   = state == ERR ? own : '0;
  // sequencer: grant and descriptor capture, engine start/run supervision, abort drain, rr advance
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state                <= FLUSH;
      cnt                  <= '0;
      own                  <= '0;
      ptr                  <= '0;
      cur_ch_o             <= '0;
      tmo_flag_o           <= 1'b0;
      target_begin_address <= '0;
      rd_address           <= '0;
      transfer_length      <= '0;
    end else begin
      case (state)
        FLUSH: state <= IDLE;
        IDLE: if (enable_i && |ch_req_i) begin
          state                <= LAUNCH;
          own                  <= arb_gnt;
          cur_ch_o             <= arb_idx;
          tmo_flag_o           <= 1'b0;
          target_begin_address <= ch_tgt_addr_i[TGT_W*int'(arb_idx) +: TGT_W];
          rd_address           <= ch_rd_addr_i[RD_W*int'(arb_idx) +: RD_W];
          transfer_length      <= ch_len_i[LEN_W*int'(arb_idx) +: LEN_W];
        end
        LAUNCH: begin
          state <= WAIT_START;
          cnt   <= '0;
        end
        WAIT_START: if (sw_abort_i || (!dma_active && cnt == TMO_BITS'(START_TMO - 1))) begin
          state <= ABORT;
          cnt   <= '0;
        end else if (dma_active) begin
          state <= RUN;
          cnt   <= TMO_BITS'(1);
        end else cnt <= cnt + 1'b1;
        RUN: if (!dma_active) state <= dma_complete_ok && !dma_err ? DONE : ERR;
        else if (sw_abort_i || tmo_hit) begin
          state      <= ABORT;
          cnt        <= '0;
          tmo_flag_o <= tmo_flag_o | tmo_hit;
        end else if (~&cnt) cnt <= cnt + 1'b1;
        ABORT: if (cnt == TMO_BITS'(ABORT_DRAIN)) state <= ERR;
        else cnt <= cnt + 1'b1;
        default: begin
          state <= IDLE;
          ptr   <= cur_ch_o == CH_BITS'(NUM_CH - 1) ? '0 : cur_ch_o + 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dma_channel_scheduler.sv
// tb_dma_channel_scheduler: directed checks of arbitration, descriptors, watchdog, aborts and reset
module tb_dma_channel_scheduler;
  localparam int NUM_CH = 4;
  localparam int CH_BITS = 2;
  localparam int TMO_BITS = 16;
  logic clk_i, rst_i, enable_i, sw_abort_i;
  logic [TMO_BITS-1:0] timeout_i;
  logic [NUM_CH-1:0] ch_req_i, ch_grant_o, ch_done_o, ch_err_o;
  logic [32*NUM_CH-1:0] ch_tgt_addr_i;
  logic [20*NUM_CH-1:0] ch_rd_addr_i;
  logic [10*NUM_CH-1:0] ch_len_i;
  logic [31:0] target_begin_address;
  logic [19:0] rd_address;
  logic [9:0] transfer_length;
  logic begin_dma, abort_dma, dma_active, dma_complete_ok, dma_err, busy_o, tmo_flag_o;
  logic [CH_BITS-1:0] cur_ch_o;
  int n_tests = 0, n_fail = 0;
  int n_begin = 0, n_abort = 0, n_done = 0, n_err = 0, n_both = 0;
  int eng_mode = 0, eng_len = 20, eng_left = 0;
  dma_channel_scheduler #(.NUM_CH(NUM_CH), .CH_BITS(CH_BITS), .TMO_BITS(TMO_BITS)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .sw_abort_i(sw_abort_i), .timeout_i(timeout_i),
    .ch_req_i(ch_req_i), .ch_tgt_addr_i(ch_tgt_addr_i), .ch_rd_addr_i(ch_rd_addr_i), .ch_len_i(ch_len_i),
    .ch_grant_o(ch_grant_o), .ch_done_o(ch_done_o), .ch_err_o(ch_err_o),
    .target_begin_address(target_begin_address), .rd_address(rd_address), .transfer_length(transfer_length),
    .begin_dma(begin_dma), .abort_dma(abort_dma), .dma_active(dma_active), .dma_complete_ok(dma_complete_ok),
    .dma_err(dma_err), .busy_o(busy_o), .cur_ch_o(cur_ch_o), .tmo_flag_o(tmo_flag_o)
  );
  initial begin
    clk_i = 0;
    forever #5 clk_i = ~clk_i;
  end
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "global timeout");
  end
  function automatic logic [31:0] exp_tgt(input int k);
    return 32'h1000_0000 + (32'(k) << 24);
  endfunction
  function automatic logic [19:0] exp_rd(input int k);
    return 20'h0A000 + 20'(k) * 20'h00111;
  endfunction
  function automatic logic [9:0] exp_len(input int k);
    return 10'(15 + 10 * k);
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(negedge clk_i);
    #1;
  endtask
  function automatic logic cond(input int k);
    return k == 0 ? begin_dma : k == 1 ? |ch_done_o : k == 2 ? |ch_err_o : abort_dma;
  endfunction
  task automatic wait_for(input int k, input int bound, output int n);
    n = 0;
    do begin
      step;
      n++;
    end while (!cond(k) && n < bound);
    if (!cond(k)) n = -1;
  endtask
  initial begin
    forever begin
      @(negedge clk_i);
      if (begin_dma) n_begin++;
      if (abort_dma) n_abort++;
      if (|ch_done_o) n_done++;
      if (|ch_err_o) n_err++;
      if (begin_dma && abort_dma) n_both++;
    end
  end
  initial begin
    logic sb, sa;
    dma_active = 0;
    dma_complete_ok = 0;
    dma_err = 0;
    forever begin
      @(negedge clk_i);
      sb = begin_dma;
      sa = abort_dma;
      @(posedge clk_i);
      #1;
      dma_complete_ok = 0;
      dma_err = 0;
      if (sa || rst_i) dma_active = 0;
      else if (sb) begin
        dma_active = eng_mode != 3;
        eng_left = eng_len;
      end else if (dma_active && eng_mode != 1) begin
        if (eng_left <= 1) begin
          dma_active = 0;
          dma_complete_ok = 1;
          dma_err = eng_mode == 2;
        end else eng_left--;
      end
    end
  end
  initial begin
    int n, nb, na, nd;
    rst_i = 1;
    enable_i = 0;
    sw_abort_i = 0;
    timeout_i = 0;
    ch_req_i = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      ch_tgt_addr_i[32*k +: 32] = exp_tgt(k);
      ch_rd_addr_i[20*k +: 20] = exp_rd(k);
      ch_len_i[10*k +: 10] = exp_len(k);
    end
    step;
    step;
    chk("rst_abort", 32'(abort_dma), 1);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_grant", 32'(ch_grant_o), 0);
    chk("rst_begin", 32'(begin_dma), 0);
    chk("rst_tgt", target_begin_address, 0);
    chk("rst_tmo", 32'(tmo_flag_o), 0);
    @(posedge clk_i);
    #1 rst_i = 0;
    step;
    chk("flush_abort", 32'(abort_dma), 1);
    step;
    chk("idle_abort", 32'(abort_dma), 0);
    chk("idle_busy", 32'(busy_o), 0);
    chk("idle_grant", 32'(ch_grant_o), 0);
    enable_i = 1;
    ch_req_i = 4'b0101;
    wait_for(0, 10, n);
    chk("a_latency", n, 1);
    chk("a_cur0", 32'(cur_ch_o), 0);
    chk("a_grant0", 32'(ch_grant_o), 1);
    chk("a_tgt0", target_begin_address, 32'h1000_0000);
    chk("a_rd0", 32'(rd_address), 32'(exp_rd(0)));
    chk("a_len0", 32'(transfer_length), 15);
    wait_for(1, 50, n);
    chk("a_done0", 32'(ch_done_o), 1);
    ch_req_i = 4'b0100;
    wait_for(0, 10, n);
    chk("a_turnaround", n, 2);
    chk("a_cur2", 32'(cur_ch_o), 2);
    chk("a_grant2", 32'(ch_grant_o), 4);
    chk("a_tgt2", target_begin_address, 32'h1200_0000);
    chk("a_len2", 32'(transfer_length), 35);
    ch_tgt_addr_i[64 +: 32] = 32'hDEAD_BEEF;
    step;
    chk("a_desc_stable", target_begin_address, 32'h1200_0000);
    wait_for(1, 50, n);
    chk("a_done2", 32'(ch_done_o), 4);
    ch_req_i = 0;
    ch_tgt_addr_i[64 +: 32] = exp_tgt(2);
    enable_i = 0;
    ch_req_i = 4'b0010;
    nb = n_begin;
    repeat (4) step;
    chk("b_disabled_begins", n_begin - nb, 0);
    chk("b_disabled_busy", 32'(busy_o), 0);
    ch_req_i = 0;
    rst_i = 1;
    step;
    @(posedge clk_i);
    #1 rst_i = 0;
    step;
    step;
    enable_i = 1;
    eng_len = 5;
    ch_req_i = 4'b1111;
    nb = n_begin;
    for (int i = 0; i < 5; i++) begin
      wait_for(0, 40, n);
      chk($sformatf("c_cur%0d", i), 32'(cur_ch_o), i % 4);
      chk($sformatf("c_grant%0d", i), 32'(ch_grant_o), 32'(1) << (i % 4));
      if (i == 4) ch_req_i = 0;
      wait_for(1, 40, n);
      chk($sformatf("c_done%0d", i), 32'(ch_done_o), 32'(1) << (i % 4));
    end
    step;
    chk("c_begins", n_begin - nb, 5);
    timeout_i = 100;
    eng_mode = 1;
    ch_req_i = 4'b0010;
    wait_for(0, 10, n);
    chk("d_cur", 32'(cur_ch_o), 1);
    na = n_abort;
    wait_for(3, 200, n);
    chk("d_tmo_cycles", n, 102);
    chk("d_tmo_flag", 32'(tmo_flag_o), 1);
    wait_for(2, 10, n);
    chk("d_err_latency", n, 3);
    chk("d_err", 32'(ch_err_o), 2);
    chk("d_abort_pulses", n_abort - na, 1);
    ch_req_i = 0;
    step;
    chk("d_flag_sticky", 32'(tmo_flag_o), 1);
    timeout_i = 0;
    eng_mode = 2;
    eng_len = 4;
    ch_req_i = 4'b1100;
    wait_for(0, 10, n);
    chk("e_cur", 32'(cur_ch_o), 2);
    chk("e_flag_clr", 32'(tmo_flag_o), 0);
    wait_for(2, 30, n);
    chk("e_err", 32'(ch_err_o), 4);
    ch_req_i = 4'b1000;
    eng_mode = 0;
    wait_for(0, 10, n);
    chk("e_next_lat", n, 2);
    chk("e_next_cur", 32'(cur_ch_o), 3);
    wait_for(1, 30, n);
    chk("e_done3", 32'(ch_done_o), 8);
    ch_req_i = 0;
    eng_len = 6;
    ch_req_i = 4'b0001;
    wait_for(0, 10, n);
    na = n_abort;
    n = 0;
    while (!(dma_complete_ok && !dma_active) && n < 30) begin
      step;
      n++;
    end
    chk("f_fall_seen", 32'(n < 30), 1);
    sw_abort_i = 1;
    step;
    sw_abort_i = 0;
    chk("f_done", 32'(ch_done_o), 1);
    chk("f_no_abort", n_abort - na, 0);
    ch_req_i = 0;
    step;
    sw_abort_i = 1;
    step;
    sw_abort_i = 0;
    chk("f_idle_abort", 32'(abort_dma), 0);
    chk("f_idle_busy", 32'(busy_o), 0);
    timeout_i = 100;
    eng_mode = 1;
    ch_req_i = 4'b0010;
    wait_for(0, 10, n);
    repeat (10) step;
    sw_abort_i = 1;
    step;
    sw_abort_i = 0;
    chk("g_abort", 32'(abort_dma), 1);
    chk("g_flag", 32'(tmo_flag_o), 0);
    wait_for(2, 10, n);
    chk("g_err", 32'(ch_err_o), 2);
    ch_req_i = 0;
    timeout_i = 0;
    eng_mode = 3;
    ch_req_i = 4'b0100;
    wait_for(0, 10, n);
    wait_for(3, 10, n);
    chk("h_nostart_cycles", n, 5);
    wait_for(2, 10, n);
    chk("h_err", 32'(ch_err_o), 4);
    ch_req_i = 0;
    eng_mode = 1;
    ch_req_i = 4'b1000;
    wait_for(0, 10, n);
    chk("i_cur", 32'(cur_ch_o), 3);
    repeat (5) step;
    chk("i_running", 32'(ch_grant_o), 8);
    nd = n_done + n_err;
    rst_i = 1;
    #1;
    chk("i_grant", 32'(ch_grant_o), 0);
    chk("i_busy", 32'(busy_o), 0);
    chk("i_abort", 32'(abort_dma), 1);
    chk("i_tgt", target_begin_address, 0);
    chk("i_len", 32'(transfer_length), 0);
    ch_req_i = 0;
    step;
    @(posedge clk_i);
    #1 rst_i = 0;
    repeat (4) step;
    chk("i_no_pulse", n_done + n_err - nd, 0);
    chk("begin_abort_excl", n_both, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
